// File: rtl/mc_main_control.sv
// ---------------------------------------------------------------------------
// mc_main_control
// Multicycle MIPS main control unit. A Moore FSM steps each instruction
// through fetch / decode / execute / memory / writeback and decodes every
// datapath strobe and mux select from the registered state. Memory
// accesses in FETCH, MEMRD and MEMWR wait on mem_ready.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode              instr[31:26] held in the instruction register
//   zero                ALU zero flag (branch condition)
//   mem_ready           memory completes the current access this cycle
//   IorD..PCSrc         datapath strobes and mux selects
//   PCEn                PC load enable = PCWrite | (Branch & zero)
//   illegal_op          one-cycle pulse when DECODE sees an unknown opcode
//   state               current state code (debug)
//   instr_retired       wrapping count of completed legal instructions
// ---------------------------------------------------------------------------
module mc_main_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_JEX    = 4'd10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Remembers whether ALUWB writes rd (R-type) or rt (addi).
    logic               rd_flag_q, rd_flag_d;

    // Raw strobes before the reset gating applied at the ports.
    logic mem_write_s, reg_write_s, ir_write_s, illegal_s;
    logic pc_write_s, branch_s, retire_s;

    // State register, retired counter and RegDst flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= {CNT_W{1'b0}};
            rd_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_flag_q <= rd_flag_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d     = state_q;
        rd_flag_d   = rd_flag_q;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        reg_write_s = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSrc       = 2'b00;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        illegal_s   = 1'b0;
        retire_s    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // PC + (imm << 2) is computed here as the branch target.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_R:         state_d = S_REXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        illegal_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                MemtoReg    = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                IorD        = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_REXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                rd_flag_d = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                RegDst      = rd_flag_q;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQEX: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                branch_s = 1'b1;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                rd_flag_d = 1'b0;
                state_d   = S_ALUWB;
            end
            S_JEX: begin
                PCSrc      = 2'b10;
                pc_write_s = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (retire_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Architectural strobes are suppressed while reset is held so an
    // abandoned instruction cannot write anything in the reset cycle.
    assign MemWrite      = mem_write_s & ~reset;
    assign RegWrite      = reg_write_s & ~reset;
    assign IRWrite       = ir_write_s  & ~reset;
    assign illegal_op    = illegal_s   & ~reset;
    assign PCEn          = (pc_write_s | (branch_s & zero)) & ~reset;
    assign state         = state_q;
    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_mc_main_control.sv
module tb_mc_main_control;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSrc;
    logic          PCEn, illegal_op;
    logic [3:0]    state;
    logic [CW-1:0] instr_retired;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int irw_cnt = 0;
    int mw_cnt = 0;

    mc_main_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op), .state(state), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accumulate pre-edge strobe samples, then advance one cycle.
    task automatic tick();
        irw_cnt += int'(IRWrite);
        mw_cnt  += int'(MemWrite);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        #1;
        tick(); tick();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_cnt", 16'(instr_retired), 16'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst_irwrite_forced", 16'(IRWrite), 16'd0);
        chk("rst_pcen_forced", 16'(PCEn), 16'd0);
        chk("rst_memread", 16'(MemRead), 16'd1);
        reset = 1'b0;
        #1;

        // R-type add: 0,1,6,7,0
        opcode = 6'b000000; cyc = 0;
        chk("r_fetch_irw", 16'(IRWrite), 16'd1);
        chk("r_fetch_pcen", 16'(PCEn), 16'd1);
        chk("r_fetch_srcb", 16'(ALUSrcB), 16'd1);
        tick();
        chk("r_st1", 16'(state), 16'd1);
        chk("r_dec_srcb", 16'(ALUSrcB), 16'd3);
        tick();
        chk("r_st6", 16'(state), 16'd6);
        chk("r_aluop", 16'(ALUOp), 16'd2);
        chk("r_srca", 16'(ALUSrcA), 16'd1);
        tick();
        chk("r_st7", 16'(state), 16'd7);
        chk("r_regwrite", 16'(RegWrite), 16'd1);
        chk("r_regdst", 16'(RegDst), 16'd1);
        chk("r_memtoreg", 16'(MemtoReg), 16'd0);
        tick();
        chk("r_st0", 16'(state), 16'd0);
        chk("r_cycles", 16'(cyc), 16'd4);
        chk("r_cnt", 16'(instr_retired), 16'd1);

        // lw with 2 FETCH stalls and 1 MEMRD stall: 8 cycles
        opcode = 6'b100011; mem_ready = 1'b0; cyc = 0; irw_cnt = 0;
        #1;
        chk("lw_fetch_stall_irw", 16'(IRWrite), 16'd0);
        tick(); tick();
        chk("lw_still_fetch", 16'(state), 16'd0);
        mem_ready = 1'b1;
        #1;
        tick();
        chk("lw_st1", 16'(state), 16'd1);
        tick();
        chk("lw_st2", 16'(state), 16'd2);
        chk("lw_memadr_srcb", 16'(ALUSrcB), 16'd2);
        tick();
        chk("lw_st3", 16'(state), 16'd3);
        chk("lw_memrd_iord", 16'(IorD), 16'd1);
        chk("lw_memrd_read", 16'(MemRead), 16'd1);
        mem_ready = 1'b0;
        #1;
        tick();
        chk("lw_memrd_hold", 16'(state), 16'd3);
        mem_ready = 1'b1;
        #1;
        tick();
        chk("lw_st4", 16'(state), 16'd4);
        chk("lw_regwrite", 16'(RegWrite), 16'd1);
        chk("lw_memtoreg", 16'(MemtoReg), 16'd1);
        chk("lw_regdst", 16'(RegDst), 16'd0);
        tick();
        chk("lw_cycles", 16'(cyc), 16'd8);
        chk("lw_irw_pulses", 16'(irw_cnt), 16'd1);
        chk("lw_cnt", 16'(instr_retired), 16'd2);

        // beq taken then not taken
        opcode = 6'b000100; zero = 1'b1; cyc = 0;
        tick(); tick();
        chk("beq1_st8", 16'(state), 16'd8);
        chk("beq1_pcen", 16'(PCEn), 16'd1);
        chk("beq1_pcsrc", 16'(PCSrc), 16'd1);
        chk("beq1_aluop", 16'(ALUOp), 16'd1);
        tick();
        chk("beq1_cycles", 16'(cyc), 16'd3);
        chk("beq1_cnt", 16'(instr_retired), 16'd3);
        zero = 1'b0;
        #1;
        tick(); tick();
        chk("beq0_st8", 16'(state), 16'd8);
        chk("beq0_pcen", 16'(PCEn), 16'd0);
        tick();
        chk("beq0_cnt", 16'(instr_retired), 16'd4);

        // addi
        opcode = 6'b001000; cyc = 0;
        tick(); tick();
        chk("addi_st9", 16'(state), 16'd9);
        chk("addi_srcb", 16'(ALUSrcB), 16'd2);
        chk("addi_aluop", 16'(ALUOp), 16'd0);
        tick();
        chk("addi_st7", 16'(state), 16'd7);
        chk("addi_regdst", 16'(RegDst), 16'd0);
        chk("addi_regwrite", 16'(RegWrite), 16'd1);
        tick();
        chk("addi_cycles", 16'(cyc), 16'd4);
        chk("addi_cnt", 16'(instr_retired), 16'd5);

        // sw with mem_ready high
        opcode = 6'b101011; cyc = 0; mw_cnt = 0;
        tick(); tick(); tick();
        chk("sw_st5", 16'(state), 16'd5);
        chk("sw_iord", 16'(IorD), 16'd1);
        tick();
        chk("sw_st0", 16'(state), 16'd0);
        chk("sw_cycles", 16'(cyc), 16'd4);
        chk("sw_memwrite_cycles", 16'(mw_cnt), 16'd1);
        chk("sw_cnt", 16'(instr_retired), 16'd6);

        // illegal opcode
        opcode = 6'b111111;
        tick();
        chk("ill_st1", 16'(state), 16'd1);
        chk("ill_pulse", 16'(illegal_op), 16'd1);
        tick();
        chk("ill_st0", 16'(state), 16'd0);
        chk("ill_pulse_gone", 16'(illegal_op), 16'd0);
        chk("ill_cnt", 16'(instr_retired), 16'd6);

        // reset in MEMWR
        opcode = 6'b101011;
        tick(); tick(); tick();
        chk("rs_st5", 16'(state), 16'd5);
        reset = 1'b1;
        #1;
        chk("rs_memwrite_forced", 16'(MemWrite), 16'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rs_st0", 16'(state), 16'd0);
        chk("rs_cnt", 16'(instr_retired), 16'd0);

        // j until the counter wraps
        opcode = 6'b000010;
        for (int i = 0; i < (1 << CW); i++) begin
            cyc = 0;
            tick(); tick();
            if (i == 0) begin
                chk("j_st10", 16'(state), 16'd10);
                chk("j_pcen", 16'(PCEn), 16'd1);
                chk("j_pcsrc", 16'(PCSrc), 16'd2);
            end
            tick();
            if (i == 0) chk("j_cycles", 16'(cyc), 16'd3);
            if (i == (1 << CW) - 2) chk("j_cnt_max", 16'(instr_retired), 16'((1 << CW) - 1));
        end
        chk("j_cnt_wrap", 16'(instr_retired), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
